// File: rtl/ram_bist.sv
// March BIST sequencer for a single-port synchronous RAM: W0, R0/W1 ascending, R1 descending.
// Reports pass/fail, the first failing address/data and a saturating mismatch count.
module ram_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] pattern,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  err_count,
    output logic [2:0]        fsm_state
);

    // Control protocol: start is a request taken only in IDLE (no back-pressure);
    // done is a one-cycle completion pulse, pass is valid from done until the next start.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0    = 3'd1,
        R0    = 3'd2,
        W1    = 3'd3,
        R1    = 3'd4,
        FLUSH = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t            state, state_next;
    logic [ADDR_W-1:0] a, a_next;
    logic [DATA_W-1:0] p, p_next;
    logic [CNT_W-1:0]  err_next;
    logic [ADDR_W-1:0] faddr_next, cmp_addr;
    logic [DATA_W-1:0] fdata_next, cmp_data;
    logic              pass_next, cmp_en;

    assign fsm_state = state;

    always_comb begin
        state_next = state;
        a_next     = a;
        p_next     = p;
        err_next   = err_count;
        faddr_next = fail_addr;
        fdata_next = fail_data;
        pass_next  = pass;
        cmp_en     = 1'b0;
        cmp_data   = ~p;
        cmp_addr   = a;

        case (state)
            IDLE: begin
                if (start) begin
                    p_next     = pattern;
                    err_next   = '0;
                    faddr_next = '0;
                    fdata_next = '0;
                    pass_next  = 1'b0;
                    a_next     = '0;
                    state_next = W0;
                end
            end
            W0: begin
                if (a == ADDR_MAX) begin
                    a_next     = '0;
                    state_next = R0;
                end else begin
                    a_next = a + ADDR_W'(1);
                end
            end
            R0: state_next = W1;
            W1: begin
                // RAM holds dout during the write, so this is the R0 read of address a.
                cmp_en   = 1'b1;
                cmp_data = p;
                if (a == ADDR_MAX) begin
                    state_next = R1;
                end else begin
                    a_next     = a + ADDR_W'(1);
                    state_next = R0;
                end
            end
            R1: begin
                // Data arriving now belongs to the read issued one address higher.
                cmp_en   = (a != ADDR_MAX);
                cmp_addr = a + ADDR_W'(1);
                if (a == '0) begin
                    state_next = FLUSH;
                end else begin
                    a_next = a - ADDR_W'(1);
                end
            end
            FLUSH: begin
                cmp_en     = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (cmp_en && (ram_dout != cmp_data)) begin
            if (err_count != CNT_MAX) begin
                err_next = err_count + CNT_W'(1);
            end
            if (err_count == '0) begin
                faddr_next = cmp_addr;
                fdata_next = ram_dout;
            end
        end

        if (state == FLUSH) begin
            pass_next = (err_next == '0);
        end

        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            a_next     = a;
            err_next   = err_count;
            faddr_next = fail_addr;
            fdata_next = fail_data;
            pass_next  = pass;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            a         <= '0;
            p         <= '0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else begin
            state     <= state_next;
            a         <= a_next;
            p         <= p_next;
            err_count <= err_next;
            fail_addr <= faddr_next;
            fail_data <= fdata_next;
            pass      <= pass_next;
            done      <= (state_next == DONE);
            busy      <= (state_next == W0) || (state_next == R0) || (state_next == W1) ||
                         (state_next == R1) || (state_next == FLUSH);
            ram_we    <= (state_next == W0) || (state_next == W1);
            ram_addr  <= a_next;
            ram_din   <= (state_next == W1) ? ~p_next : p_next;
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist driving a behavioral 256x8 RAM with injectable stuck-at bits.
module tb_ram_bist;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [7:0] ram_din;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] err_count;
    logic [2:0] fsm_state;

    ram_bist #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .ram_din   (ram_din),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_count (err_count),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: faulty bits are forced on the read path
    logic [7:0] mem [256];
    logic [7:0] sa0 [256];
    logic [7:0] sa1 [256];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout <= (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];
    end

    // Scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    int k;
    int busy_cnt;
    int done_cnt;
    int done_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drivers
    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            sa0[i] = 8'h00;
            sa1[i] = 8'h00;
        end
    endtask

    task automatic sample();
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
        end
    endtask

    // Issue start so the next rising edge is cycle 0; returns observing cycle 1.
    task automatic start_march(input logic [7:0] p);
        @(negedge clk);
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        k        = 1;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        sample();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        sample();
    endtask

    task automatic run_until(input int cyc);
        while (k < cyc) step();
    endtask

    task automatic run_to_done(input int limit);
        while ((done_cyc < 0) && (k < limit)) step();
        step();
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_faults();
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = 8'h00;
        k = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        chk("reset_busy",  busy, 1'b0);
        chk("reset_done",  done, 1'b0);
        chk("reset_pass",  pass, 1'b0);
        chk("reset_we",    ram_we, 1'b0);
        chk("reset_err",   err_count, 8'h00);
        chk("reset_state", fsm_state, 3'd0);

        // Fault-free march, P=0xA5
        start_march(8'hA5);
        chk("w0_first_we",   ram_we, 1'b1);
        chk("w0_first_addr", ram_addr, 8'h00);
        chk("w0_first_din",  ram_din, 8'hA5);
        run_to_done(2000);
        chk("ff_done_cyc",  done_cyc, 32'd1026);
        chk("ff_busy_cnt",  busy_cnt, 32'd1025);
        chk("ff_pass",      pass, 1'b1);
        chk("ff_err",       err_count, 8'h00);
        chk("ff_fail_addr", fail_addr, 8'h00);

        // Stuck-at-0 on bit 0 at 0x3C
        sa0[8'h3C] = 8'h01;
        start_march(8'hA5);
        run_to_done(2000);
        chk("sa0_done_cyc",  done_cyc, 32'd1026);
        chk("sa0_pass",      pass, 1'b0);
        chk("sa0_err",       err_count, 8'h01);
        chk("sa0_fail_addr", fail_addr, 8'h3C);
        chk("sa0_fail_data", fail_data, 8'hA4);
        clear_faults();

        // Stuck-at-1 on bit 7 at 0x00 and 0xFF, P=0xFF
        sa1[8'h00] = 8'h80;
        sa1[8'hFF] = 8'h80;
        start_march(8'hFF);
        run_to_done(2000);
        chk("sa1_pass",      pass, 1'b0);
        chk("sa1_err",       err_count, 8'h02);
        chk("sa1_fail_addr", fail_addr, 8'hFF);
        chk("sa1_fail_data", fail_data, 8'h80);
        clear_faults();

        // Abort in cycle 900 (R1) with an earlier R0 mismatch recorded
        sa0[8'h3C] = 8'h01;
        start_march(8'hA5);
        run_until(900);
        chk("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state",     fsm_state, 3'd0);
        chk("abort_busy",      busy, 1'b0);
        chk("abort_we",        ram_we, 1'b0);
        chk("abort_pass",      pass, 1'b0);
        chk("abort_err",       err_count, 8'h01);
        chk("abort_fail_addr", fail_addr, 8'h3C);
        repeat (200) step();
        chk("abort_no_done",   done_cnt, 32'd0);
        clear_faults();

        // Asynchronous reset inside W0, then a full march
        start_march(8'h5A);
        run_until(100);
        chk("rst_pre_we", ram_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_busy",      busy, 1'b0);
        chk("rst_we",        ram_we, 1'b0);
        chk("rst_addr",      ram_addr, 8'h00);
        chk("rst_din",       ram_din, 8'h00);
        chk("rst_done",      done, 1'b0);
        chk("rst_pass",      pass, 1'b0);
        chk("rst_err",       err_count, 8'h00);
        chk("rst_fail_addr", fail_addr, 8'h00);
        chk("rst_fail_data", fail_data, 8'h00);
        chk("rst_state",     fsm_state, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        start_march(8'h3C);
        run_to_done(2000);
        chk("rst_rerun_done_cyc", done_cyc, 32'd1026);
        chk("rst_rerun_pass",     pass, 1'b1);

        // Start with pattern 0x00 during R0/W1 must be ignored
        start_march(8'hA5);
        run_until(300);
        pattern = 8'h00;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("ign_busy", busy, 1'b1);
        run_until(520);
        if (ram_we) chk("ign_w1_din", ram_din, 8'h5A);
        else        chk("ign_r0_we",  ram_we, 1'b0);
        run_to_done(2000);
        chk("ign_done_cyc", done_cyc, 32'd1026);
        chk("ign_busy_cnt", busy_cnt, 32'd1025);
        chk("ign_pass",     pass, 1'b1);
        chk("ign_err",      err_count, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
